// File: rtl/red_pitaya_fads_sorter.sv
// rtl/red_pitaya_fads_sorter.sv - FADS droplet sorter: segments the ADC trace, gates peak/width, fires a delayed sort pulse.
// Optional statistics counters are built when FADS_STATS_EN is defined.
module red_pitaya_fads_sorter #(
    parameter int DW = 14,
    parameter int WW = 16,
    parameter int TW = 16,
    parameter int CW = 32
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rst_i,
    input  logic signed [DW-1:0] adc_dat_i,
    input  logic                 cfg_en_i,
    input  logic signed [DW-1:0] cfg_det_thr_i,
    input  logic signed [DW-1:0] cfg_low_thr_i,
    input  logic signed [DW-1:0] cfg_high_thr_i,
    input  logic [WW-1:0]        cfg_min_width_i,
    input  logic [WW-1:0]        cfg_max_width_i,
    input  logic [TW-1:0]        cfg_delay_i,
    input  logic [TW-1:0]        cfg_pulse_len_i,
    output logic                 droplet_o,
    output logic                 det_valid_o,
    output logic signed [DW-1:0] det_peak_o,
    output logic [WW-1:0]        det_width_o,
    output logic                 det_pos_o,
    output logic                 sort_trig_o,
    output logic [CW-1:0]        stat_drops_o,
    output logic [CW-1:0]        stat_sorts_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DROPLET = 3'd1,
        S_DECIDE  = 3'd2,
        S_DELAY   = 3'd3,
        S_PULSE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 armed_q;
    logic [WW-1:0]        width_q, width_d;
    logic signed [DW-1:0] peak_q, peak_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic                 droplet_q, droplet_d;
    logic                 det_valid_q, det_valid_d;
    logic signed [DW-1:0] det_peak_q, det_peak_d;
    logic [WW-1:0]        det_width_q, det_width_d;
    logic                 det_pos_q, det_pos_d;
    logic                 trig_q, trig_d;

    logic above;
    logic pos_w;

    assign above = adc_dat_i > cfg_det_thr_i;

    // Inverted windows (low>=high or min>max) can never satisfy both sides.
    assign pos_w = (cfg_low_thr_i < peak_q) && (peak_q < cfg_high_thr_i) &&
                   (cfg_min_width_i <= width_q) && (width_q <= cfg_max_width_i);

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q && above) state_d = S_DROPLET;
                end
                S_DROPLET: begin
                    if (!above) state_d = S_DECIDE;
                end
                S_DECIDE: begin
                    if (det_pos_q && (cfg_pulse_len_i != '0)) begin
                        state_d = (cfg_delay_i != '0) ? S_DELAY : S_PULSE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DELAY: begin
                    if (cnt_q == TW'(1)) state_d = S_PULSE;
                end
                S_PULSE: begin
                    if (cnt_q == TW'(1)) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        width_d     = width_q;
        peak_d      = peak_q;
        cnt_d       = cnt_q;
        det_peak_d  = det_peak_q;
        det_width_d = det_width_q;
        det_pos_d   = det_pos_q;
        case (state_q)
            S_IDLE: begin
                width_d = WW'(1);
                peak_d  = adc_dat_i;
            end
            S_DROPLET: begin
                if (above) begin
                    if (width_q != '1) width_d = width_q + WW'(1);
                    if (adc_dat_i > peak_q) peak_d = adc_dat_i;
                end
            end
            S_DECIDE: begin
                cnt_d = (cfg_delay_i != '0) ? cfg_delay_i : cfg_pulse_len_i;
            end
            S_DELAY: begin
                cnt_d = (cnt_q == TW'(1)) ? cfg_pulse_len_i : cnt_q - TW'(1);
            end
            S_PULSE: begin
                cnt_d = cnt_q - TW'(1);
            end
            default: ;
        endcase
        det_valid_d = (state_d == S_DECIDE);
        if (det_valid_d) begin
            det_peak_d  = peak_q;
            det_width_d = width_q;
            det_pos_d   = pos_w;
        end
        droplet_d = (state_d == S_DROPLET);
        trig_d    = (state_d == S_PULSE);
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            armed_q     <= 1'b0;
            width_q     <= '0;
            peak_q      <= '0;
            cnt_q       <= '0;
            droplet_q   <= 1'b0;
            det_valid_q <= 1'b0;
            det_peak_q  <= '0;
            det_width_q <= '0;
            det_pos_q   <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            armed_q     <= !above;
            width_q     <= width_d;
            peak_q      <= peak_d;
            cnt_q       <= cnt_d;
            droplet_q   <= droplet_d;
            det_valid_q <= det_valid_d;
            det_peak_q  <= det_peak_d;
            det_width_q <= det_width_d;
            det_pos_q   <= det_pos_d;
            trig_q      <= trig_d;
        end
    end

    assign droplet_o   = droplet_q;
    assign det_valid_o = det_valid_q;
    assign det_peak_o  = det_peak_q;
    assign det_width_o = det_width_q;
    assign det_pos_o   = det_pos_q;
    assign sort_trig_o = trig_q;

`ifdef FADS_STATS_EN
    logic [CW-1:0] stat_drops_q, stat_sorts_q;

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            stat_drops_q <= '0;
            stat_sorts_q <= '0;
        end else begin
            if (det_valid_d) stat_drops_q <= stat_drops_q + CW'(1);
            if ((state_d == S_PULSE) && (state_q != S_PULSE)) stat_sorts_q <= stat_sorts_q + CW'(1);
        end
    end

    assign stat_drops_o = stat_drops_q;
    assign stat_sorts_o = stat_sorts_q;
`else
    assign stat_drops_o = '0;
    assign stat_sorts_o = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
// tb/tb_red_pitaya_fads_sorter.sv - scoreboard bench for red_pitaya_fads_sorter.
module tb_red_pitaya_fads_sorter;
    localparam int DW = 14;
    localparam int WW = 16;
    localparam int TW = 16;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic signed [DW-1:0] adc;
    logic                 en;
    int c_det, c_low, c_high, c_min, c_max, c_delay, c_plen;

    logic                 droplet, det_valid, det_pos, sort_trig;
    logic signed [DW-1:0] det_peak;
    logic [WW-1:0]        det_width;
    logic [CW-1:0]        stat_drops, stat_sorts;

    logic signed [DW-1:0] cfg_det, cfg_low, cfg_high;
    logic [WW-1:0]        cfg_min, cfg_max;
    logic [TW-1:0]        cfg_delay, cfg_plen;
    assign cfg_det   = c_det[DW-1:0];
    assign cfg_low   = c_low[DW-1:0];
    assign cfg_high  = c_high[DW-1:0];
    assign cfg_min   = c_min[WW-1:0];
    assign cfg_max   = c_max[WW-1:0];
    assign cfg_delay = c_delay[TW-1:0];
    assign cfg_plen  = c_plen[TW-1:0];

    red_pitaya_fads_sorter #(.DW(DW), .WW(WW), .TW(TW), .CW(CW)) dut (
        .adc_clk_i(clk), .adc_rst_i(rst), .adc_dat_i(adc), .cfg_en_i(en),
        .cfg_det_thr_i(cfg_det), .cfg_low_thr_i(cfg_low), .cfg_high_thr_i(cfg_high),
        .cfg_min_width_i(cfg_min), .cfg_max_width_i(cfg_max),
        .cfg_delay_i(cfg_delay), .cfg_pulse_len_i(cfg_plen),
        .droplet_o(droplet), .det_valid_o(det_valid), .det_peak_o(det_peak),
        .det_width_o(det_width), .det_pos_o(det_pos), .sort_trig_o(sort_trig),
        .stat_drops_o(stat_drops), .stat_sorts_o(stat_sorts)
    );

    typedef struct {
        logic signed [DW-1:0] peak;
        logic [WW-1:0]        width;
        logic                 pos;
    } det_t;

    det_t det_q[$];
    int   gap_q[$];
    int   len_q[$];
    int   tests = 0;
    int   fails = 0;

    int   cyc = 0;
    int   last_det = 0;
    det_t e;
    int   exp_gap, exp_len, cur_len;
    bit   have_exp = 0;
    logic trig_prev = 1'b0;

    // Scoreboard monitors: detection results and pulse timing.
    always @(negedge clk) begin
        cyc++;
        if (det_valid === 1'b1) begin
            last_det = cyc;
            tests++;
            if (det_q.size() == 0) begin
                fails++;
                $display("FAIL det_unexpected got peak=%0d width=%0d pos=%0d", det_peak, det_width, det_pos);
            end else begin
                e = det_q.pop_front();
                if (det_peak !== e.peak || det_width !== e.width || det_pos !== e.pos) begin
                    fails++;
                    $display("FAIL det_result got peak=%0d width=%0d pos=%0d exp peak=%0d width=%0d pos=%0d",
                             det_peak, det_width, det_pos, e.peak, e.width, e.pos);
                end
            end
        end
        if (sort_trig === 1'b1 && trig_prev !== 1'b1) begin
            tests++;
            cur_len = 0;
            if (gap_q.size() == 0) begin
                fails++;
                have_exp = 0;
                $display("FAIL pulse_unexpected got rise at cycle %0d exp none", cyc);
            end else begin
                exp_gap = gap_q.pop_front();
                exp_len = len_q.pop_front();
                have_exp = 1;
                if (cyc - last_det != exp_gap) begin
                    fails++;
                    $display("FAIL pulse_gap got %0d exp %0d", cyc - last_det, exp_gap);
                end
            end
        end
        if (sort_trig === 1'b1) cur_len++;
        if (sort_trig !== 1'b1 && trig_prev === 1'b1 && have_exp) begin
            tests++;
            have_exp = 0;
            if (cur_len != exp_len) begin
                fails++;
                $display("FAIL pulse_len got %0d exp %0d", cur_len, exp_len);
            end
        end
        trig_prev = sort_trig;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        adc = '0;
        repeat (n) tick();
    endtask

    task automatic settle();
        idle(c_delay + c_plen + 6);
    endtask

    task automatic set_defaults();
        c_det = 100; c_low = 500; c_high = 2000; c_min = 3; c_max = 10;
        c_delay = 4; c_plen = 5; en = 1'b1;
    endtask

    // Drives one rising-crossing droplet and pushes its expected results.
    task automatic send_drop(input int n, input int pk, input bit flat);
        int   pk_m;
        int   w;
        int   v;
        bit   pos;
        det_t d;
        pk_m = -100000;
        for (int i = 0; i < n; i++) begin
            v = (flat || i == n / 2) ? pk : 150;
            if (v > pk_m) pk_m = v;
            adc = v[DW-1:0];
            tick();
        end
        adc = '0;
        w = (n > 65535) ? 65535 : n;
        pos = (c_low < pk_m) && (pk_m < c_high) && (c_min <= w) && (w <= c_max);
        d.peak  = pk_m[DW-1:0];
        d.width = w[WW-1:0];
        d.pos   = pos;
        det_q.push_back(d);
        if (pos && c_plen != 0) begin
            gap_q.push_back(c_delay + 1);
            len_q.push_back(c_plen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adc = 14'sd1000;
        set_defaults();
        repeat (3) tick();
        tests++;
        if (droplet !== 1'b0 || det_valid !== 1'b0 || det_peak !== '0 || det_width !== '0 ||
            det_pos !== 1'b0 || sort_trig !== 1'b0 || stat_drops !== '0 || stat_sorts !== '0) begin
            fails++;
            $display("FAIL reset_outputs got drop=%0d dv=%0d pk=%0d w=%0d pos=%0d trig=%0d sd=%0d ss=%0d exp all 0",
                     droplet, det_valid, det_peak, det_width, det_pos, sort_trig, stat_drops, stat_sorts);
        end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_baseline();
        send_drop(6, 1000, 1'b1);
        settle();
    endtask

    task automatic test_windows();
        send_drop(6, 2500, 1'b1); settle();
        send_drop(2, 1000, 1'b1); settle();
        send_drop(6, 2000, 1'b1); settle();
        send_drop(3, 501, 1'b0);  settle();
        send_drop(10, 1999, 1'b0); settle();
        send_drop(11, 1000, 1'b1); settle();
        c_low = 2000; c_high = 500;
        send_drop(6, 1000, 1'b1); settle();
        c_low = 500; c_high = 2000; c_min = 8; c_max = 4;
        send_drop(6, 1000, 1'b1); settle();
        set_defaults();
    endtask

    task automatic test_short_pulse();
        c_delay = 0; c_plen = 1;
        send_drop(6, 1000, 1'b1); settle();
        c_delay = 4; c_plen = 0;
        send_drop(6, 1000, 1'b1); settle();
        set_defaults();
    endtask

    task automatic test_back_to_back();
        send_drop(6, 1000, 1'b1);
        idle(2);
        adc = 14'sd1000;
        repeat (6) tick();
        settle();
        send_drop(6, 1000, 1'b1);
        idle(2);
        adc = 14'sd1000;
        repeat (12) tick();
        tests++;
        if (droplet !== 1'b0) begin
            fails++;
            $display("FAIL held_above_measured got droplet=%0d exp 0", droplet);
        end
        idle(3);
        settle();
        send_drop(4, 800, 1'b1);
        settle();
    endtask

    task automatic abort_pulse(input bit use_rst);
        int n;
        send_drop(6, 1000, 1'b1);
        len_q[len_q.size() - 1] = 2;
        n = 0;
        do begin
            tick();
            n++;
        end while (sort_trig !== 1'b1 && n < 50);
        tests++;
        if (sort_trig !== 1'b1) begin
            fails++;
            $display("FAIL abort_wait got trig=%0d exp 1 within 50 cycles", sort_trig);
        end
        tick();
        if (use_rst) rst = 1'b1; else en = 1'b0;
        tick();
        tests++;
        if (sort_trig !== 1'b0 || droplet !== 1'b0) begin
            fails++;
            $display("FAIL abort_%s got trig=%0d droplet=%0d exp 0 0", use_rst ? "rst" : "en", sort_trig, droplet);
        end
        rst = 1'b0;
        en = 1'b1;
        settle();
    endtask

    task automatic test_abort();
        abort_pulse(1'b0);
        abort_pulse(1'b1);
        idle(3);
        adc = 14'sd1000;
        repeat (3) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (3) tick();
        tests++;
        if (droplet !== 1'b0) begin
            fails++;
            $display("FAIL en_low_droplet got droplet=%0d exp 0", droplet);
        end
        settle();
    endtask

    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);
        send_drop(6, 1000, 1'b1); settle();
        send_drop(6, 2500, 1'b1); settle();
        send_drop(5, 800, 1'b1);  settle();
        tests++;
`ifdef FADS_STATS_EN
        if (stat_drops !== 32'd3 || stat_sorts !== 32'd2) begin
            fails++;
            $display("FAIL stats got drops=%0d sorts=%0d exp 3 2", stat_drops, stat_sorts);
        end
`else
        if (stat_drops !== '0 || stat_sorts !== '0) begin
            fails++;
            $display("FAIL stats_tied got drops=%0d sorts=%0d exp 0 0", stat_drops, stat_sorts);
        end
`endif
    endtask

    task automatic test_saturation();
        send_drop(70000, 1000, 1'b1);
        settle();
    endtask

    task automatic test_end();
        idle(20);
        tests++;
        if (det_q.size() != 0 || gap_q.size() != 0 || have_exp) begin
            fails++;
            $display("FAIL scoreboard_drain got det=%0d pulse=%0d pending=%0d exp 0 0 0",
                     det_q.size(), gap_q.size(), have_exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        adc = '0;
        set_defaults();
        test_reset();
        test_baseline();
        test_windows();
        test_short_pulse();
        test_back_to_back();
        test_abort();
        test_stats();
        test_saturation();
        test_end();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
